// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide sequencer signal bundle.
// The master side is the EX stage and the slave side is the sequencer.
interface muldiv_if;
  logic        start;
  logic [5:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        stallreq_ex;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  stallreq_ex, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output stallreq_ex, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO: shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up applied at commit.
module muldiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int DATA_W = 32;
  localparam int CW     = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                skip_q, skip_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                stall, done;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v, input logic sgn);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return (sgn && v[DATA_W-1]) ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v, input logic en);
    return en ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] v, input logic en);
    return en ? (~v + (2*DATA_W)'(1)) : v;
  endfunction

  // op is one-hot {mthi, mtlo, mult, multu, div, divu}
  logic op_mthi, op_mtlo, op_mult, op_multu, op_div, op_divu, op_md, op_sgn;
  assign op_mthi  = bus.op[5];
  assign op_mtlo  = bus.op[4];
  assign op_mult  = bus.op[3];
  assign op_multu = bus.op[2];
  assign op_div   = bus.op[1];
  assign op_divu  = bus.op[0];
  assign op_md    = op_mult | op_multu | op_div | op_divu;
  assign op_sgn   = op_mult | op_div;

  // One iteration: multiply adds the multiplicand on the multiplier LSB then
  // shifts right; divide shifts left and keeps the trial subtraction if it fits.
  logic [DATA_W:0]     add_sum, rem_sh;
  logic [DATA_W+1:0]   sub_diff;
  logic [2*DATA_W-1:0] step;
  always_comb begin
    add_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
    sub_diff = {1'b0, rem_sh} - {2'b00, b_q};
    if (is_div_q)
      step = sub_diff[DATA_W+1] ? {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                : {sub_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    else
      step = {add_sum, acc_q[DATA_W-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    skip_d    = skip_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          if (op_md) begin
            stall     = 1'b1;
            is_div_d  = op_div | op_divu;
            neg_res_d = op_sgn & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
            neg_rem_d = op_div & bus.src_a[DATA_W-1];
            cnt_d     = '0;
            if (op_div | op_divu) begin
              acc_d = {{DATA_W{1'b0}}, mag(bus.src_a, op_sgn)};
              b_d   = mag(bus.src_b, op_sgn);
            end else begin
              acc_d = {{DATA_W{1'b0}}, mag(bus.src_b, op_sgn)};
              b_d   = mag(bus.src_a, op_sgn);
            end
            skip_d  = (op_div | op_divu) && (bus.src_b == '0);
            state_d = ((op_div | op_divu) && (bus.src_b == '0)) ? DONE : CALC;
          end else if (op_mthi) begin
            hi_d = bus.src_a;
          end else if (op_mtlo) begin
            lo_d = bus.src_a;
          end
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          acc_d = step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!bus.cancel) begin
          done = 1'b1;
          if (!skip_q) begin
            if (is_div_q) begin
              lo_d = neg32(acc_q[DATA_W-1:0], neg_res_q);
              hi_d = neg32(acc_q[2*DATA_W-1:DATA_W], neg_rem_q);
            end else begin
              {hi_d, lo_d} = neg64(acc_q, neg_res_q);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      skip_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      skip_q    <= skip_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.stallreq_ex = stall;
  assign bus.done        = done;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO pushed when an op is driven,
// popped and compared when the done pulse commits it.
module tb_muldiv_ctrl;
  localparam int ITER = 32;
  localparam logic [5:0] OP_MTHI  = 6'b100000;
  localparam logic [5:0] OP_MTLO  = 6'b010000;
  localparam logic [5:0] OP_MULT  = 6'b001000;
  localparam logic [5:0] OP_MULTU = 6'b000100;
  localparam logic [5:0] OP_DIV   = 6'b000010;
  localparam logic [5:0] OP_DIVU  = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if bus();
  muldiv_ctrl #(.ITER(ITER)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int done_total = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  always @(negedge clk) if (bus.done === 1'b1) done_total++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 0) return {hi, lo};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic run_md(input string tag, input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int stalls, d0, exp_st;
    bit got;
    exp = model(o, a, b, m_hi, m_lo);
    sb_q.push_back(exp);
    {m_hi, m_lo} = exp;
    exp_st = ((o == OP_DIV || o == OP_DIVU) && b == 0) ? 1 : ITER + 1;
    d0 = done_total;
    stalls = 0;
    got = 0;
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    for (int c = 0; c < ITER + 8 && !got; c++) begin
      @(negedge clk);
      if (bus.stallreq_ex === 1'b1) stalls++;
      if (bus.done === 1'b1) got = 1;
      @(posedge clk); #1;
      bus.src_a = $urandom; bus.src_b = $urandom;
      if (got) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    if (!got) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      exp = sb_q.pop_back();
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
    end
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_st));
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, 64'(done_total - d0), 64'd1);
  endtask

  task automatic run_mt(input string tag, input logic [5:0] o, input logic [31:0] a);
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = $urandom;
    @(negedge clk);
    check({tag, "_stall"}, {63'd0, bus.stallreq_ex}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (o == OP_MTHI) m_hi = a; else m_lo = a;
    check({tag, "_hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  initial begin
    int d0;
    logic [5:0] rops [4];
    rops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_stall_done", {62'd0, bus.stallreq_ex, bus.done}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_md("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_const", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    run_md("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5);
    check("mult_neg_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_md("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    check("divu_const", {bus.hi, bus.lo}, 64'h00000002_0000000E);
    run_md("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2);
    check("div_neg_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_md("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_const", {bus.hi, bus.lo}, 64'h00000000_80000000);
    run_md("divu_by0", OP_DIVU, 32'd5, 32'd0);
    check("divu_by0_const", {bus.hi, bus.lo}, 64'h00000000_80000000);
    run_mt("mthi", OP_MTHI, 32'h12345678);
    run_mt("mtlo", OP_MTLO, 32'hCAFEF00D);
    check("mt_const", {bus.hi, bus.lo}, 64'h12345678_CAFEF00D);
    run_md("div_by0", OP_DIV, 32'hFFFF0000, 32'd0);

    for (int i = 0; i < 6; i++)
      run_md($sformatf("rand%0d", i), rops[i % 4], $urandom, $urandom);

    // start while cancel is asserted in IDLE must do nothing
    d0 = done_total;
    bus.start = 1'b1; bus.op = OP_MULT; bus.src_a = 32'd9; bus.src_b = 32'd9; bus.cancel = 1'b1;
    #1;
    check("idle_cancel_stall", {63'd0, bus.stallreq_ex}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_cancel_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    check("idle_cancel_done", 64'(done_total - d0), 64'd0);

    // cancel with the counter at 10
    d0 = done_total;
    bus.start = 1'b1; bus.op = OP_DIV; bus.src_a = 32'hFFFFFF9C; bus.src_b = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    check("calc_stall_before_cancel", {63'd0, bus.stallreq_ex}, 64'd1);
    bus.cancel = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel_stall_after", {63'd0, bus.stallreq_ex}, 64'd0);
    repeat (ITER + 4) @(posedge clk);
    #1;
    check("cancel_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    check("cancel_done", 64'(done_total - d0), 64'd0);

    // asynchronous reset in the middle of CALC
    bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd7; bus.src_b = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midcalc_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midcalc_rst_stall", {63'd0, bus.stallreq_ex}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    run_md("post_rst_multu", OP_MULTU, 32'd3, 32'd4);
    check("post_rst_lo", {32'd0, bus.lo}, 64'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
